uart_frame_parser: RTL

//   Sequences the UART receiver's byte handshake and assembles framed commands:

---
 rtl/uart_frame_parser.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_parser.sv
// UART command frame parser: HEADER CMD LEN PAYLOAD[LEN] CHK.
// Drives the receiver byte handshake and holds a checked frame until acked.
module uart_frame_parser #(
  parameter logic [7:0] HEADER      = 8'h55,
  parameter int         MAX_LEN     = 16,
  parameter int         LEN_W       = 5,
  parameter int         ADDR_W      = 4,
  parameter int         TIMEOUT_CYC = 520800,
  parameter int         TO_W        = 20
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [7:0]        rx_data,
  input  logic              flag_rxne,
  output logic              read_done,
  output logic              frame_valid,
  output logic [7:0]        frame_cmd,
  output logic [LEN_W-1:0]  frame_len,
  input  logic [ADDR_W-1:0] pay_addr,
  output logic [7:0]        pay_data,
  input  logic              frame_ack,
  output logic              err_chk,
  output logic              err_len,
  output logic              err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_PAY,
    S_CHK,
    S_DONE
  } state_t;

  state_t             r_state;
  logic               r_armed;
  logic               r_read_done;
  logic [7:0]         r_cmd;
  logic [7:0]         r_sum;
  logic [LEN_W-1:0]   r_len;
  logic [ADDR_W-1:0]  r_idx;
  logic [TO_W-1:0]    r_to_cnt;
  logic [7:0]         r_frame_cmd;
  logic [LEN_W-1:0]   r_frame_len;
  logic [7:0]         r_pay_data;
  logic               r_err_chk;
  logic               r_err_len;
  logic               r_err_to;
  logic [7:0]         r_buf [2**ADDR_W];

  logic               w_accept;
  logic               w_idx_last;
  logic               w_to_hit;
  logic               w_len_bad;

  assign w_accept   = flag_rxne & r_armed & (r_state != S_DONE);
  assign w_idx_last = (LEN_W'(r_idx) == r_len - LEN_W'(1));
  assign w_to_hit   = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign w_len_bad  = (rx_data > 8'(MAX_LEN));

  assign read_done   = r_read_done;
  assign frame_valid = (r_state == S_DONE);
  assign frame_cmd   = r_frame_cmd;
  assign frame_len   = r_frame_len;
  assign pay_data    = r_pay_data;
  assign err_chk     = r_err_chk;
  assign err_len     = r_err_len;
  assign err_timeout = r_err_to;

  // Handshake: one low read_done pulse per byte, re-arm once flag drops
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_armed     <= 1'b1;
      r_read_done <= 1'b1;
    end else begin
      r_read_done <= ~w_accept;
      if (w_accept)
        r_armed <= 1'b0;
      else if (!flag_rxne)
        r_armed <= 1'b1;
    end
  end

  // Frame FSM with inter-byte timeout and error pulses
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= S_IDLE;
      r_cmd       <= '0;
      r_sum       <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_to_cnt    <= '0;
      r_frame_cmd <= '0;
      r_frame_len <= '0;
      r_err_chk   <= 1'b0;
      r_err_len   <= 1'b0;
      r_err_to    <= 1'b0;
    end else begin
      r_err_chk <= 1'b0;
      r_err_len <= 1'b0;
      r_err_to  <= 1'b0;
      if (w_accept) begin
        r_to_cnt <= '0;
        case (r_state)
          S_IDLE: begin
            if (rx_data == HEADER)
              r_state <= S_CMD;
          end
          S_CMD: begin
            r_cmd   <= rx_data;
            r_sum   <= rx_data;
            r_state <= S_LEN;
          end
          S_LEN: begin
            if (w_len_bad) begin
              r_err_len <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_len   <= rx_data[LEN_W-1:0];
              r_sum   <= r_sum + rx_data;
              r_idx   <= '0;
              r_state <= (rx_data == 8'd0) ? S_CHK : S_PAY;
            end
          end
          S_PAY: begin
            r_sum <= r_sum + rx_data;
            if (w_idx_last)
              r_state <= S_CHK;
            else
              r_idx <= r_idx + ADDR_W'(1);
          end
          S_CHK: begin
            if (rx_data == r_sum) begin
              r_frame_cmd <= r_cmd;
              r_frame_len <= r_len;
              r_state     <= S_DONE;
            end else begin
              r_err_chk <= 1'b1;
              r_state   <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end else begin
        case (r_state)
          S_CMD, S_LEN, S_PAY, S_CHK: begin
            if (w_to_hit) begin
              r_err_to <= 1'b1;
              r_to_cnt <= '0;
              r_state  <= S_IDLE;
            end else begin
              r_to_cnt <= r_to_cnt + TO_W'(1);
            end
          end
          S_DONE: begin
            r_to_cnt <= '0;
            if (frame_ack)
              r_state <= S_IDLE;
          end
          default: r_to_cnt <= '0;
        endcase
      end
    end
  end

  // Payload store; contents survive reset
  always_ff @(posedge sys_clk) begin
    if (w_accept && r_state == S_PAY)
      r_buf[r_idx] <= rx_data;
  end

  // Registered payload read port
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      r_pay_data <= '0;
    else
      r_pay_data <= r_buf[pay_addr];
  end

endmodule
